// File: rtl/snn_step_ctrl.sv
// Timestep scheduler for the layered SNN datapath: clear, frame intake, per-layer start/forward.
// Optional watchdog on layer completion is enabled with `define SNN_CTRL_TIMEOUT_EN.
module snn_step_ctrl #(
    parameter int NUM_LAYERS  = 2,
    parameter int NUM_STEPS   = 16,
    parameter int STEP_W      = 5,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [NUM_LAYERS-1:0] layer_done_i,
    output logic [NUM_LAYERS-1:0] layer_start_o,
    output logic [NUM_LAYERS-1:0] next_stage_o,
    output logic                  mem_clr_o,
    output logic [STEP_W-1:0]     step_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [2:0]            state_o
);

    localparam int KW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam logic [KW-1:0]     K_LAST = KW'(NUM_LAYERS - 1);
    localparam logic [STEP_W-1:0] S_LAST = STEP_W'(NUM_STEPS - 1);

    if (NUM_LAYERS < 1 || NUM_STEPS < 1 || TIMEOUT_CYC < 1 ||
        NUM_STEPS > (1 << STEP_W)) begin : g_param_check
        $error("snn_step_ctrl: invalid parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CLEAR     = 3'd1,
        S_WAIT_IN   = 3'd2,
        S_START     = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_ADVANCE   = 3'd5,
        S_FIN       = 3'd6
    } state_t;

    state_t                state, nxt_state;
    logic [KW-1:0]         k, nxt_k;
    logic [STEP_W-1:0]     nxt_step;
    logic                  nxt_err;
    logic                  timeout;
    logic [NUM_LAYERS-1:0] nxt_onehot;

    assign state_o    = state;
    assign nxt_onehot = NUM_LAYERS'(1) << nxt_k;

`ifdef SNN_CTRL_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wdog;

    assign timeout = (state == S_WAIT_DONE) && (wdog == WD_W'(TIMEOUT_CYC - 1));

    // Held at zero outside WAIT_DONE, so every entry starts a fresh count.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wdog <= '0;
        end else if (state != S_WAIT_DONE) begin
            wdog <= '0;
        end else if (!timeout) begin
            wdog <= wdog + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Frame handshake: in_ready_o is high only in WAIT_IN; a frame transfers on the
    // rising edge where in_valid_i and in_ready_o are both high.
    always_comb begin
        nxt_state = state;
        nxt_k     = k;
        nxt_step  = step_o;
        nxt_err   = err_o;
        if (abort_i && state != S_IDLE) begin
            nxt_state = S_IDLE;
            nxt_k     = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        nxt_state = S_CLEAR;
                        nxt_err   = 1'b0;
                    end
                end
                S_CLEAR: begin
                    nxt_state = S_WAIT_IN;
                    nxt_step  = '0;
                end
                S_WAIT_IN: begin
                    if (in_valid_i) begin
                        nxt_state = S_START;
                        nxt_k     = '0;
                    end
                end
                S_START: nxt_state = S_WAIT_DONE;
                S_WAIT_DONE: begin
                    if (layer_done_i[k]) begin
                        nxt_state = S_ADVANCE;
                    end else if (timeout) begin
                        nxt_state = S_IDLE;
                        nxt_k     = '0;
                        nxt_err   = 1'b1;
                    end
                end
                S_ADVANCE: begin
                    if (k != K_LAST) begin
                        nxt_k     = k + 1'b1;
                        nxt_state = S_START;
                    end else if (step_o == S_LAST) begin
                        nxt_state = S_FIN;
                    end else begin
                        nxt_step  = step_o + 1'b1;
                        nxt_state = S_WAIT_IN;
                    end
                end
                S_FIN:   nxt_state = S_IDLE;
                default: nxt_state = S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they are registered yet still
    // line up with the cycle the FSM spends in the corresponding state.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state         <= S_IDLE;
            k             <= '0;
            step_o        <= '0;
            err_o         <= 1'b0;
            in_ready_o    <= 1'b0;
            layer_start_o <= '0;
            next_stage_o  <= '0;
            mem_clr_o     <= 1'b0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
        end else begin
            state         <= nxt_state;
            k             <= nxt_k;
            step_o        <= nxt_step;
            err_o         <= nxt_err;
            in_ready_o    <= (nxt_state == S_WAIT_IN);
            layer_start_o <= (nxt_state == S_START)   ? nxt_onehot : '0;
            next_stage_o  <= (nxt_state == S_ADVANCE) ? nxt_onehot : '0;
            mem_clr_o     <= (nxt_state == S_CLEAR);
            busy_o        <= (nxt_state != S_IDLE);
            done_o        <= (nxt_state == S_FIN);
        end
    end

endmodule
